// File: rtl/mem_arbiter_if.sv
// Cache/RAM bus bundle for mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the
// caches and the RAM model that surround it.
interface mem_arbiter_if #(
    parameter int NCPU = 2
);
    logic [NCPU-1:0]      iREN;
    logic [NCPU*32-1:0]   iaddr;
    logic [NCPU-1:0]      iwait;
    logic [31:0]          iload;
    logic [NCPU-1:0]      dREN;
    logic [NCPU-1:0]      dWEN;
    logic [NCPU*32-1:0]   daddr;
    logic [NCPU*32-1:0]   dstore;
    logic [NCPU-1:0]      dlock;
    logic [NCPU-1:0]      dwait;
    logic [31:0]          dload;
    logic                 ram_ren;
    logic                 ram_wen;
    logic [31:0]          ram_addr;
    logic [31:0]          ram_store;
    logic [31:0]          ram_load;
    logic                 ram_ready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, dlock, ram_load, ram_ready,
        output iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, dlock, ram_load, ram_ready,
        input  iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-word RAM port between the icaches and dcaches of
// NCPU cores. Class priority dcache write > dcache read > icache read, round-robin
// across cores inside a class, and a dcache may keep its grant for up to BLK_WORDS
// consecutive words by holding dlock so block fills/writebacks are atomic.
// RAM strobes, wait bits and load data are combinational from the live grant so a
// word completes in the same cycle the RAM reports ram_ready.
module mem_arbiter #(
    parameter int NCPU      = 2,
    parameter int BLK_WORDS = 2
) (
    input  logic           CLK,
    input  logic           nRST,
    mem_arbiter_if.slave   bus
);
    localparam int CW = (NCPU > 1) ? $clog2(NCPU) : 1;
    localparam int KW = $clog2(BLK_WORDS + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t          state_q;
    logic            gnt_dc_q;     // granted requester is a dcache
    logic [CW-1:0]   core_q;       // granted core
    logic [CW-1:0]   rr_q;         // round-robin start point
    logic [KW-1:0]   cnt_q;        // words served under the current grant

    logic [NCPU-1:0] wr_req_s;
    logic [NCPU-1:0] rd_req_s;
    logic [NCPU-1:0] cls_req_s;
    logic            cls_dc_s;
    logic            arb_any_s;
    logic [CW-1:0]   arb_core_s;

    logic            live_s;
    logic            done_s;
    logic            hold_s;
    logic [KW-1:0]   cnt_inc_s;
    logic [CW-1:0]   rr_next_s;
    logic            ren_s;
    logic            wen_s;
    logic [31:0]     addr_s;
    logic [31:0]     store_s;
    logic [NCPU-1:0] iwait_s;
    logic [NCPU-1:0] dwait_s;
    logic [31:0]     iload_s;
    logic [31:0]     dload_s;

    // Pick the highest non-empty class, then the first requester at or after rr.
    always_comb begin
        int idx;
        wr_req_s   = bus.dWEN;
        rd_req_s   = bus.dREN & ~bus.dWEN;
        arb_any_s  = |(bus.dWEN | bus.dREN | bus.iREN);
        arb_core_s = '0;
        if (|wr_req_s) begin
            cls_req_s = wr_req_s;
            cls_dc_s  = 1'b1;
        end else if (|rd_req_s) begin
            cls_req_s = rd_req_s;
            cls_dc_s  = 1'b1;
        end else begin
            cls_req_s = bus.iREN;
            cls_dc_s  = 1'b0;
        end
        // Walk backwards so the closest core after rr is written last and wins.
        for (int k = NCPU - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NCPU;
            if (cls_req_s[idx]) begin
                arb_core_s = CW'(idx);
            end else begin
                arb_core_s = arb_core_s;
            end
        end
    end

    // Drive the RAM port from the granted core's current inputs while in ACCESS.
    always_comb begin
        live_s  = 1'b0;
        ren_s   = 1'b0;
        wen_s   = 1'b0;
        addr_s  = 32'h0000_0000;
        store_s = 32'h0000_0000;
        if (state_q == ACCESS) begin
            if (gnt_dc_q) begin
                live_s  = bus.dREN[core_q] | bus.dWEN[core_q];
                wen_s   = bus.dWEN[core_q];
                ren_s   = bus.dREN[core_q] & ~bus.dWEN[core_q];
                addr_s  = bus.daddr[32*int'(core_q) +: 32];
                store_s = bus.dstore[32*int'(core_q) +: 32];
            end else begin
                live_s  = bus.iREN[core_q];
                ren_s   = bus.iREN[core_q];
                addr_s  = bus.iaddr[32*int'(core_q) +: 32];
            end
        end else begin
            live_s = 1'b0;
        end
    end

    // Word completion: wait pulse, load data and the lock/release decision.
    always_comb begin
        done_s    = live_s & bus.ram_ready;
        cnt_inc_s = cnt_q + KW'(1);
        hold_s    = gnt_dc_q & bus.dlock[core_q] & (cnt_inc_s < KW'(BLK_WORDS));
        rr_next_s = (int'(core_q) == NCPU - 1) ? '0 : core_q + CW'(1);
        iwait_s   = '1;
        dwait_s   = '1;
        iload_s   = 32'h0000_0000;
        dload_s   = 32'h0000_0000;
        if (done_s) begin
            if (gnt_dc_q) begin
                dwait_s[core_q] = 1'b0;
                dload_s         = bus.ram_load;
            end else begin
                iwait_s[core_q] = 1'b0;
                iload_s         = bus.ram_load;
            end
        end else begin
            iwait_s = '1;
        end
    end

    // Arbiter FSM: latch a grant in IDLE, serve words in ACCESS, release on done or drop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            gnt_dc_q <= 1'b0;
            core_q   <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any_s) begin
                        state_q  <= ACCESS;
                        gnt_dc_q <= cls_dc_s;
                        core_q   <= arb_core_s;
                        cnt_q    <= '0;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!live_s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (bus.ram_ready) begin
                        if (hold_s) begin
                            cnt_q <= cnt_inc_s;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            rr_q    <= rr_next_s;
                        end
                    end else begin
                        state_q <= ACCESS;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.ram_ren   = ren_s;
    assign bus.ram_wen   = wen_s;
    assign bus.ram_addr  = addr_s;
    assign bus.ram_store = store_s;
    assign bus.iwait     = iwait_s;
    assign bus.dwait     = dwait_s;
    assign bus.iload     = iload_s;
    assign bus.dload     = dload_s;
endmodule
